// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter in front of a 4:1, 4-bit selector: one-hot grant with bounded tenure,
// registered select, and a registered data word that trails the grant by one cycle.
module mux4_rr_arbiter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] REQ,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  output logic [3:0] GNT,
  output logic       S0,
  output logic       S1,
  output logic [3:0] Dout,
  output logic       DVALID
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] dout_q, dout_d;
  logic       dvalid_q, dvalid_d;

  logic [1:0] win;
  logic       win_vld;
  logic [3:0] d_sel;
  logic       hold_req;
  logic       release_now;

  // Scan from the farthest candidate back to the nearest so the first in
  // round-robin order (last+1 ... last) is the one left standing.
  always_comb begin
    win     = last_q;
    win_vld = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (REQ[last_q + 2'(k)]) begin
        win     = last_q + 2'(k);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    d_sel = D0;
      2'd1:    d_sel = D1;
      2'd2:    d_sel = D2;
      default: d_sel = D3;
    endcase
  end

  assign hold_req    = REQ[sel_q];
  assign release_now = !hold_req || (cnt_q == CNT_MAX);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;

    // Capture uses the holder as it stands before this edge's re-arbitration.
    if (state_q == ST_GRANT && hold_req) begin
      dout_d   = d_sel;
      dvalid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          last_d  = win;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        if (release_now) begin
          if (win_vld) begin
            gnt_d  = 4'b0001 << win;
            sel_d  = win;
            last_d = win;
            cnt_d  = 4'd0;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= ST_IDLE;
      last_q   <= 2'd3;
      sel_q    <= 2'd0;
      cnt_q    <= 4'd0;
      gnt_q    <= 4'b0000;
      dout_q   <= 4'b0000;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign GNT    = gnt_q;
  assign S1     = sel_q[1];
  assign S0     = sel_q[0];
  assign Dout   = dout_q;
  assign DVALID = dvalid_q;

endmodule
